// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three single-entry holding slots (ALU, LSB, BRU) drained
// round-robin onto one registered broadcast bus, with flush and a global stall.
module cdb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned NSRC       = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  rdy_alu_in,
  input  logic                  rdy_lsb_in,
  input  logic                  rdy_bru_in,
  input  logic [DATA_WIDTH-1:0] result_alu_in,
  input  logic [DATA_WIDTH-1:0] result_lsb_in,
  input  logic [DATA_WIDTH-1:0] result_bru_in,
  input  logic [ROB_WIDTH-1:0]  rob_id_alu_in,
  input  logic [ROB_WIDTH-1:0]  rob_id_lsb_in,
  input  logic [ROB_WIDTH-1:0]  rob_id_bru_in,
  output logic                  full_alu_out,
  output logic                  full_lsb_out,
  output logic                  full_bru_out,
  output logic                  rdy_cdb_out,
  output logic [DATA_WIDTH-1:0] result_cdb_out,
  output logic [ROB_WIDTH-1:0]  rob_id_cdb_out,
  output logic [1:0]            src_cdb_out
);

  logic [NSRC-1:0]       valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [NSRC];
  logic [DATA_WIDTH-1:0] data_d [NSRC];
  logic [ROB_WIDTH-1:0]  tag_q  [NSRC];
  logic [ROB_WIDTH-1:0]  tag_d  [NSRC];
  logic [1:0]            last_q, last_d;

  logic                  bus_rdy_q, bus_rdy_d;
  logic [DATA_WIDTH-1:0] bus_data_q, bus_data_d;
  logic [ROB_WIDTH-1:0]  bus_tag_q, bus_tag_d;
  logic [1:0]            bus_src_q, bus_src_d;

  logic [NSRC-1:0]       in_valid;
  logic [DATA_WIDTH-1:0] in_data [NSRC];
  logic [ROB_WIDTH-1:0]  in_tag  [NSRC];
  logic [1:0]            order   [NSRC];
  logic                  grant;
  logic [1:0]            winner;

  always_comb begin
    in_valid   = {rdy_bru_in, rdy_lsb_in, rdy_alu_in};
    in_data[0] = result_alu_in;
    in_data[1] = result_lsb_in;
    in_data[2] = result_bru_in;
    in_tag[0]  = rob_id_alu_in;
    in_tag[1]  = rob_id_lsb_in;
    in_tag[2]  = rob_id_bru_in;
  end

  // Search order starts one past the last winner.
  always_comb begin
    case (last_q)
      2'd0:    order = '{2'd1, 2'd2, 2'd0};
      2'd1:    order = '{2'd2, 2'd0, 2'd1};
      default: order = '{2'd0, 2'd1, 2'd2};
    endcase
    grant  = 1'b0;
    winner = 2'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (!grant && valid_q[order[i]]) begin
        grant  = 1'b1;
        winner = order[i];
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    tag_d      = tag_q;
    last_d     = last_q;
    bus_rdy_d  = bus_rdy_q;
    bus_data_d = bus_data_q;
    bus_tag_d  = bus_tag_q;
    bus_src_d  = bus_src_q;
    if (flush_in) begin
      valid_d   = '0;
      bus_rdy_d = 1'b0;
    end else if (rdy_in) begin
      // Writes need an empty slot, so they never collide with that slot's grant.
      for (int s = 0; s < NSRC; s++) begin
        if (in_valid[s] && !valid_q[s] && (in_tag[s] != '0)) begin
          valid_d[s] = 1'b1;
          data_d[s]  = in_data[s];
          tag_d[s]   = in_tag[s];
        end
      end
      if (grant) begin
        bus_rdy_d       = 1'b1;
        bus_data_d      = data_q[winner];
        bus_tag_d       = tag_q[winner];
        bus_src_d       = winner;
        valid_d[winner] = 1'b0;
        last_d          = winner;
      end else begin
        bus_rdy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q    <= '0;
      data_q     <= '{default: '0};
      tag_q      <= '{default: '0};
      last_q     <= 2'd2;
      bus_rdy_q  <= 1'b0;
      bus_data_q <= '0;
      bus_tag_q  <= '0;
      bus_src_q  <= 2'd0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      last_q     <= last_d;
      bus_rdy_q  <= bus_rdy_d;
      bus_data_q <= bus_data_d;
      bus_tag_q  <= bus_tag_d;
      bus_src_q  <= bus_src_d;
    end
  end

  assign full_alu_out   = valid_q[0];
  assign full_lsb_out   = valid_q[1];
  assign full_bru_out   = valid_q[2];
  assign rdy_cdb_out    = bus_rdy_q;
  assign result_cdb_out = bus_data_q;
  assign rob_id_cdb_out = bus_tag_q;
  assign src_cdb_out    = bus_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a slot/round-robin reference model.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        flush_in;
  logic        wv [3];
  logic [31:0] wd [3];
  logic [3:0]  wt [3];
  logic        full_alu_out, full_lsb_out, full_bru_out;
  logic        rdy_cdb_out;
  logic [31:0] result_cdb_out;
  logic [3:0]  rob_id_cdb_out;
  logic [1:0]  src_cdb_out;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          mv [3];
  logic [31:0] md [3];
  logic [3:0]  mt [3];
  int          mlast;
  bit          mrdy;
  logic [31:0] mres;
  logic [3:0]  mtag;
  int          msrc;

  always #5 clk_in = ~clk_in;

  cdb_arbiter dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .flush_in      (flush_in),
    .rdy_alu_in    (wv[0]),
    .rdy_lsb_in    (wv[1]),
    .rdy_bru_in    (wv[2]),
    .result_alu_in (wd[0]),
    .result_lsb_in (wd[1]),
    .result_bru_in (wd[2]),
    .rob_id_alu_in (wt[0]),
    .rob_id_lsb_in (wt[1]),
    .rob_id_bru_in (wt[2]),
    .full_alu_out  (full_alu_out),
    .full_lsb_out  (full_lsb_out),
    .full_bru_out  (full_bru_out),
    .rdy_cdb_out   (rdy_cdb_out),
    .result_cdb_out(result_cdb_out),
    .rob_id_cdb_out(rob_id_cdb_out),
    .src_cdb_out   (src_cdb_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("full_alu", 64'(full_alu_out), 64'(mv[0]));
    chk("full_lsb", 64'(full_lsb_out), 64'(mv[1]));
    chk("full_bru", 64'(full_bru_out), 64'(mv[2]));
    chk("rdy_cdb", 64'(rdy_cdb_out), 64'(mrdy));
    chk("result_cdb", 64'(result_cdb_out), 64'(mres));
    chk("rob_id_cdb", 64'(rob_id_cdb_out), 64'(mtag));
    chk("src_cdb", 64'(src_cdb_out), 64'(msrc));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0; md[i] = '0; mt[i] = '0;
    end
    mlast = 2; mrdy = 0; mres = '0; mtag = '0; msrc = 0;
  endtask

  // Advance the model by one edge from the inputs currently applied.
  task automatic model_edge();
    int win;
    bit old_v [3];
    if (flush_in) begin
      for (int i = 0; i < 3; i++) mv[i] = 0;
      mrdy = 0;
    end else if (rdy_in) begin
      old_v = mv;
      win = -1;
      for (int k = 1; k <= 3; k++)
        if (win < 0 && old_v[(mlast + k) % 3]) win = (mlast + k) % 3;
      for (int s = 0; s < 3; s++)
        if (wv[s] && !old_v[s] && wt[s] != 0) begin
          mv[s] = 1; md[s] = wd[s]; mt[s] = wt[s];
        end
      if (win >= 0) begin
        mrdy = 1; mres = md[win]; mtag = mt[win]; msrc = win;
        mv[win] = 0; mlast = win;
      end else begin
        mrdy = 0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      wv[i] = 0; wd[i] = '0; wt[i] = '0;
    end
    rdy_in = 1; flush_in = 0;
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear before any edge.
  task automatic async_reset();
    #2;
    rst_n_in = 0;
    #1;
    chk("rst_full_alu", 64'(full_alu_out), 64'd0);
    chk("rst_full_lsb", 64'(full_lsb_out), 64'd0);
    chk("rst_full_bru", 64'(full_bru_out), 64'd0);
    chk("rst_rdy_cdb", 64'(rdy_cdb_out), 64'd0);
    chk("rst_result", 64'(result_cdb_out), 64'd0);
    chk("rst_tag", 64'(rob_id_cdb_out), 64'd0);
    chk("rst_src", 64'(src_cdb_out), 64'd0);
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1;
  endtask

  initial begin
    rst_n_in = 0;
    clear_inputs();
    model_reset();
    #2;
    check_all();
    @(negedge clk_in);
    rst_n_in = 1;

    // Single ALU result
    wv[0] = 1; wt[0] = 4'd5; wd[0] = 32'h1234;
    step();
    chk("single_full", 64'(full_alu_out), 64'd1);
    clear_inputs();
    step();
    chk("single_rdy", 64'(rdy_cdb_out), 64'd1);
    chk("single_tag", 64'(rob_id_cdb_out), 64'd5);
    chk("single_data", 64'(result_cdb_out), 64'h1234);
    chk("single_src", 64'(src_cdb_out), 64'd0);
    step();
    chk("single_rdy_off", 64'(rdy_cdb_out), 64'd0);

    // All three at once, drained in order 0,1,2
    async_reset();
    for (int i = 0; i < 3; i++) begin
      wv[i] = 1; wt[i] = 4'(i + 1); wd[i] = 32'(100 + i);
    end
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("all3_src", 64'(src_cdb_out), 64'(i));
      chk("all3_tag", 64'(rob_id_cdb_out), 64'(i + 1));
      chk("all3_fulls", 64'({full_bru_out, full_lsb_out, full_alu_out}),
          64'((3'b111 << (i + 1)) & 3'b111));
    end
    step();
    chk("all3_done", 64'(rdy_cdb_out), 64'd0);

    // ALU and BRU rewriting whenever empty: alternating grants
    async_reset();
    for (int c = 0; c < 10; c++) begin
      wv[0] = !mv[0]; wt[0] = 4'($urandom_range(15, 1)); wd[0] = $urandom;
      wv[2] = !mv[2]; wt[2] = 4'($urandom_range(15, 1)); wd[2] = $urandom;
      step();
      if (c >= 1) begin
        chk("rr_rdy", 64'(rdy_cdb_out), 64'd1);
        chk("rr_src", 64'(src_cdb_out), (c % 2 == 1) ? 64'd0 : 64'd2);
      end
    end
    clear_inputs();

    // Stall with LSB slot full, write while full dropped
    async_reset();
    wv[1] = 1; wt[1] = 4'd7; wd[1] = 32'haa;
    step();
    rdy_in = 0; wt[1] = 4'd9; wd[1] = 32'hbb;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_full", 64'(full_lsb_out), 64'd1);
      chk("stall_rdy", 64'(rdy_cdb_out), 64'd0);
    end
    rdy_in = 1;
    step();
    chk("stall_bcast_tag", 64'(rob_id_cdb_out), 64'd7);
    chk("stall_bcast_data", 64'(result_cdb_out), 64'haa);
    chk("stall_bcast_src", 64'(src_cdb_out), 64'd1);
    clear_inputs();
    step();
    chk("stall_dropped", 64'(full_lsb_out), 64'd0);

    // Flush with two slots full and bus active
    async_reset();
    for (int i = 0; i < 3; i++) begin
      wv[i] = 1; wt[i] = 4'(i + 10); wd[i] = 32'(i);
    end
    step();
    clear_inputs();
    step();
    chk("pre_flush_rdy", 64'(rdy_cdb_out), 64'd1);
    flush_in = 1; wv[0] = 1; wt[0] = 4'd4; wd[0] = 32'h55;
    step();
    chk("flush_fulls", 64'({full_bru_out, full_lsb_out, full_alu_out}), 64'd0);
    chk("flush_rdy", 64'(rdy_cdb_out), 64'd0);
    clear_inputs();
    step();

    // Tag 0 write is ignored, then reset while a slot is full
    wv[0] = 1; wt[0] = 4'd0; wd[0] = 32'h77;
    step();
    chk("tag0_full", 64'(full_alu_out), 64'd0);
    clear_inputs();
    step();
    chk("tag0_rdy", 64'(rdy_cdb_out), 64'd0);
    wv[1] = 1; wt[1] = 4'd3; wd[1] = 32'h33;
    step();
    chk("pre_rst_full", 64'(full_lsb_out), 64'd1);
    async_reset();
    clear_inputs();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rdy_in   = ($urandom % 8) != 0;
      flush_in = ($urandom % 40) == 0;
      for (int i = 0; i < 3; i++) begin
        wv[i] = $urandom % 2;
        wt[i] = 4'($urandom);
        wd[i] = $urandom;
      end
      if ($urandom % 500 == 0) async_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, result width; ROB_WIDTH, default 4, ROB tag width; NSRC, fixed 3, number of requesters (0=ALU, 1=LSB, 2=BRU).
REQ-002 clk_in  input  1  the only clock; all state updates on its rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous and active-low.
REQ-004 rdy_in  input  1  global enable; low freezes all state except for flush.
REQ-005 flush_in  input  1  misprediction flush; discards all pending and outgoing results.
REQ-006 rdy_alu_in / rdy_lsb_in / rdy_bru_in  input  1 each  requester result valid.
REQ-007 result_alu_in / result_lsb_in / result_bru_in  input  DATA_WIDTH each  requester result value.
REQ-008 rob_id_alu_in / rob_id_lsb_in / rob_id_bru_in  input  ROB_WIDTH each  requester destination ROB tag.
REQ-009 full_alu_out / full_lsb_out / full_bru_out  output  1 each  requester holding slot occupied; driven directly from the slot-valid register.
REQ-010 rdy_cdb_out  output  1  broadcast valid, registered.
REQ-011 result_cdb_out  output  DATA_WIDTH  broadcast value, registered.
REQ-012 rob_id_cdb_out  output  ROB_WIDTH  broadcast ROB tag, registered.
REQ-013 src_cdb_out  output  2  index of the requester that owns the current broadcast, registered.

Function
REQ-014 Each requester SHALL own one holding slot (valid, value, tag).
REQ-015 A write into slot s SHALL occur at a clock edge where rdy_in=1, flush_in=0, rdy_s_in=1, full_s_out=0 and rob_id_s_in!=0.
REQ-016 A write with full_s_out=1 SHALL be dropped; the slot contents SHALL stay unchanged.
REQ-017 A write with rob_id_s_in=0 SHALL be dropped, because tag 0 is reserved to mean "no dependency".
REQ-018 Arbitration SHALL run at each edge with rdy_in=1 and flush_in=0, using slot-valid values sampled before that edge.
REQ-019 The arbiter SHALL grant the first valid slot in round-robin order, starting at (last_grant+1) mod 3.
REQ-020 On a grant, the winner's value, tag and index SHALL load into the output registers, rdy_cdb_out<=1, the winner's slot SHALL clear, and last_grant<=winner.
REQ-021 With no valid slot, rdy_cdb_out<=0; the data, tag and src outputs SHALL hold their previous values; last_grant SHALL stay unchanged.
REQ-022 Latency: a result accepted at edge N SHALL reach the bus at edge N+1 at the earliest.
REQ-023 Throughput SHALL be one broadcast per cycle while any slot is valid.
REQ-024 A slot granted at edge N SHALL report full=0 after edge N and SHALL accept a new write at edge N+1.
REQ-025 Write and grant for the same slot SHALL NOT coincide, because writes require full=0 at the edge.
REQ-026 With rdy_in=0 and flush_in=0, every register SHALL hold, including rdy_cdb_out, and all writes SHALL be dropped.
REQ-027 flush_in=1 at an edge SHALL clear all slot-valid bits and set rdy_cdb_out<=0, regardless of rdy_in.
REQ-028 During a flush edge, writes and grants SHALL be suppressed and last_grant SHALL hold.
REQ-029 Each rdy_cdb_out pulse SHALL carry exactly one accepted result; no result SHALL be broadcast twice or reordered within a single requester.

Reset
REQ-030 While rst_n_in=0, all slot-valid bits SHALL be 0, rdy_cdb_out=0, result_cdb_out=0, rob_id_cdb_out=0, src_cdb_out=0, last_grant=2 (so the first grant search starts at ALU), and all full_*_out=0.
REQ-031 Reset assertion SHALL take effect immediately, without waiting for a clock edge, and SHALL abandon any in-flight result, including mid-broadcast.
REQ-032 The first write SHALL be accepted at the first rising edge after rst_n_in deasserts.

Verification
REQ-033 Single ALU result, tag 5, value 0x1234 at edge 1 -> edge 2: rdy_cdb_out=1, rob_id_cdb_out=5, result_cdb_out=0x1234, src_cdb_out=0; edge 3: rdy_cdb_out=0.
REQ-034 All three requesters write at edge 1 (tags 1, 2, 3) after reset -> edges 2, 3, 4 broadcast src 0, 1, 2 in that order; full_*_out drop one per edge.
REQ-035 ALU and BRU rewrite every cycle they are not full, LSB idle -> grants alternate 0, 2, 0, 2; neither requester is starved.
REQ-036 LSB slot full, rdy_in=0 for 3 cycles -> bus and slot hold; rdy_in back to 1 -> broadcast on the next edge; a write attempted while full is dropped.
REQ-037 Two slots full and rdy_cdb_out=1, flush_in=1 at one edge -> after that edge all full_*_out=0 and rdy_cdb_out=0; a write on the same edge as the flush is dropped.
REQ-038 Write with tag 0 -> no broadcast and full stays 0; rst_n_in pulsed low mid-cycle while a slot is full -> outputs clear immediately, without waiting for a clock edge.
